psk_symbol_mapper: RTL and testbench
====================================

// Module: psk_symbol_mapper
// PURPOSE
//  Transmit-side BPSK/QPSK symbol mapper: consumes payload bytes on a valid/ready stream, serialises bits
//  MSB first, maps them to signed I/Q baseband levels and holds each symbol for SPS output samples.
//  Feeds the TX pulse-shaping/upconversion chain; the same is_bpsk control also drives the RX error-detect path.
//  Mode is sampled per byte, so a mode flip never splits a byte across two constellations.
// PARAMETERS
//  WIDTH  16     I/Q sample width (signed)
//  AMP    8192   constellation amplitude; legal range 1..2^(WIDTH-1)-1
//  SPS    8      output samples per symbol; legal range >= 1
// PORTS
//  clk           in   1      clock
//  rst           in   1      reset, asynchronous, active-high
//  is_bpsk       in   1      1: BPSK, 0: QPSK; sampled on byte acceptance
//  in_tdata      in   8      payload byte
//  in_tvalid     in   1      byte valid
//  in_tready     out  1      mapper can accept a byte this cycle
//  out_I_tdata   out  WIDTH  I sample (signed)
//  out_I_tvalid  out  1      I sample valid
//  out_Q_tdata   out  WIDTH  Q sample (signed)
//  out_Q_tvalid  out  1      Q sample valid (always equal to out_I_tvalid)
//  out_tready    in   1      downstream accepts current I/Q sample
//  sym_start     out  1      high with the first sample of every symbol
//  busy          out  1      byte in progress (shift register not empty)
// BEHAVIOUR
//  Reset: all outputs 0 (in_tready 0 during rst, 1 the first cycle after); shift reg, counters, mode_q cleared;
//   a partially sent byte is discarded, no further samples of it emitted.
//  Handshake: sample fires when out_*_tvalid & out_tready; byte fires when in_tvalid & in_tready.
//  While out_*_tvalid=1 & out_tready=0, out_I/Q_tdata, valid and sym_start hold stable.
//  in_tready = !busy | (last sample of last symbol of current byte is firing this cycle) -> no bubble.
//  Byte accept edge: load shift reg, latch mode_q <= is_bpsk, load first symbol into output regs;
//   first sample visible in the next cycle (latency 1), sym_start=1 with it.
//  Sample counter 0..SPS-1 advances only on sample fire; wraps at SPS-1 -> next symbol, sym_start=1.
//  BPSK (mode_q=1): 8 symbols/byte; bit 0 -> I=+AMP, bit 1 -> I=-AMP; Q=0.
//  QPSK (mode_q=0): 4 symbols/byte, pairs (b7,b6),(b5,b4),..; first bit -> I, second -> Q; 0->+AMP, 1->-AMP.
//  -AMP computed in WIDTH bits, never -2^(WIDTH-1) (guaranteed by AMP range).
//  Underflow: last sample fires with no byte available -> valid 0, data 0, sym_start 0, busy 0 next cycle.
//  is_bpsk change mid-byte: ignored until next byte acceptance.
//  SPS=1: every fired sample is a new symbol, sym_start high on every valid sample.
//  in_tvalid with in_tready=0: byte not consumed; sender must hold it (standard stream rule).
// STRUCTURE
//  Shared package psk_pkg: MODE_BPSK=1'b1, MODE_QPSK=1'b0, BPSK_SYMS_PER_BYTE=8, QPSK_SYMS_PER_BYTE=4,
//   sign-map function bit->+/-AMP (shared with RX slicers).
//  One sub-module: symbol_timer (sample counter 0..SPS-1, symbol counter, last_sample/last_symbol flags).
//  Top: byte shift reg, mode_q, I/Q map, registered outputs, ready logic.
// TESTING
//  1 BPSK, AMP=8192, SPS=4, byte 8'hA5, out_tready=1 -> 32 samples, I=-,+,-,+,+,-,+,- x8192 each x4, Q=0.
//  2 QPSK, byte 8'h1B -> symbols (I,Q)=(+,+),(+,-),(-,+),(-,-) x8192, 4 samples each, sym_start every 4th.
//  3 Back-to-back bytes 8'h00,8'hFF BPSK -> in_tready high on last sample of byte 1, 64 contiguous valid
//    samples, no gap, sign flips exactly at sample 32.
//  4 out_tready toggled randomly -> output sequence identical to case 1; data stable while stalled.
//  5 is_bpsk 1->0 mid-byte of 8'hA5 then byte 8'h1B -> first byte fully BPSK (32 samples), second QPSK (16).
//  6 rst asserted mid-byte after 10 samples -> outputs 0 same cycle; next byte 8'h80 BPSK starts fresh,
//    first symbol I=-8192; SPS=1 variant: sym_start on every sample.

Source files
------------

// File: rtl/psk_symbol_mapper_pkg.sv
//------------------------------------------------------------------------------
// Module  : psk_pkg
// Purpose : Shared constants and helpers for the BPSK/QPSK mapper and the RX
//           slicers: mode encodings, symbols per byte and the bit -> +/-AMP
//           sign map.
// Ports   : none (package)
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package psk_pkg;

    localparam logic MODE_BPSK          = 1'b1;
    localparam logic MODE_QPSK          = 1'b0;
    localparam int   BPSK_SYMS_PER_BYTE = 8;
    localparam int   QPSK_SYMS_PER_BYTE = 4;
    localparam int   SYM_CNT_W          = 3;

    typedef logic [SYM_CNT_W-1:0] sym_cnt_t;

    // Bit 0 maps to +amp, bit 1 to -amp. The caller truncates to its sample
    // width; amp is kept below 2^(WIDTH-1) so -amp never hits the most
    // negative code.
    function automatic logic signed [31:0] sign_map(input logic neg, input int amp);
        return neg ? -amp : amp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/psk_symbol_mapper_if.sv
//------------------------------------------------------------------------------
// Module  : psk_symbol_mapper_if
// Purpose : Byte input stream, I/Q sample output stream and status of the
//           PSK symbol mapper.
// Ports   : is_bpsk, in_tdata/in_tvalid/in_tready (byte stream),
//           out_I_*/out_Q_*/out_tready (sample stream), sym_start, busy.
//           slave modport = mapper side, master modport = source/sink side.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface psk_symbol_mapper_if #(
    parameter int WIDTH = 16
);
    logic                    is_bpsk;
    logic [7:0]              in_tdata;
    logic                    in_tvalid;
    logic                    in_tready;
    logic signed [WIDTH-1:0] out_I_tdata;
    logic                    out_I_tvalid;
    logic signed [WIDTH-1:0] out_Q_tdata;
    logic                    out_Q_tvalid;
    logic                    out_tready;
    logic                    sym_start;
    logic                    busy;

    modport slave (
        input  is_bpsk, in_tdata, in_tvalid, out_tready,
        output in_tready, out_I_tdata, out_I_tvalid, out_Q_tdata, out_Q_tvalid,
               sym_start, busy
    );

    modport master (
        output is_bpsk, in_tdata, in_tvalid, out_tready,
        input  in_tready, out_I_tdata, out_I_tvalid, out_Q_tdata, out_Q_tvalid,
               sym_start, busy
    );
endinterface

`default_nettype wire

// File: rtl/psk_symbol_mapper_symbol_timer.sv
//------------------------------------------------------------------------------
// Module  : psk_symbol_mapper_symbol_timer
// Purpose : Sample counter 0..SPS-1 and symbol counter within a byte; flags
//           the last sample of a symbol and the last symbol of a byte.
// Ports   : clk, rst (async, active-high)
//           load        - byte accepted, restart both counters
//           fire        - output sample accepted downstream
//           bpsk        - mode of the byte in progress (8 or 4 symbols)
//           last_sample - current sample is the last of its symbol
//           last_symbol - current symbol is the last of its byte
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module psk_symbol_mapper_symbol_timer
    import psk_pkg::*;
#(
    parameter int SPS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic fire,
    input  logic bpsk,
    output logic last_sample,
    output logic last_symbol
);

    localparam int             c_sw          = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [c_sw-1:0] c_last_sample = c_sw'(SPS - 1);
    localparam sym_cnt_t        c_bpsk_last   = sym_cnt_t'(BPSK_SYMS_PER_BYTE - 1);
    localparam sym_cnt_t        c_qpsk_last   = sym_cnt_t'(QPSK_SYMS_PER_BYTE - 1);

    logic [c_sw-1:0] r_sample;
    sym_cnt_t        r_symbol;

    assign last_sample = (r_sample == c_last_sample);
    assign last_symbol = (bpsk == MODE_BPSK) ? (r_symbol == c_bpsk_last)
                                             : (r_symbol == c_qpsk_last);

    // A load coincides either with an idle mapper or with the final sample
    // firing, so it simply restarts both counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample <= '0;
            r_symbol <= '0;
        end else if (load) begin
            r_sample <= '0;
            r_symbol <= '0;
        end else if (fire) begin
            if (last_sample) begin
                r_sample <= '0;
                r_symbol <= last_symbol ? '0 : r_symbol + sym_cnt_t'(1);
            end else begin
                r_sample <= r_sample + c_sw'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/psk_symbol_mapper.sv
//------------------------------------------------------------------------------
// Module  : psk_symbol_mapper
// Purpose : TX BPSK/QPSK symbol mapper. Accepts payload bytes, serialises them
//           MSB first, maps bits to signed I/Q levels (+/-AMP) and holds each
//           symbol for SPS output samples. Mode is latched per byte.
// Ports   : clk, rst (async, active-high)
//           bus (slave) - is_bpsk, in_* byte stream, out_I_*/out_Q_* sample
//                         stream with out_tready, sym_start, busy
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module psk_symbol_mapper
    import psk_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMP   = 8192,
    parameter int SPS   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    psk_symbol_mapper_if.slave   bus
);

    logic signed [WIDTH-1:0] r_i;
    logic signed [WIDTH-1:0] r_q;
    logic                    r_valid;
    logic                    r_sym_start;
    logic                    r_mode;
    // Bits still to be sent, left-aligned; the symbol on the outputs has
    // already been shifted out.
    logic [7:0]              r_shift;

    logic       w_last_sample;
    logic       w_last_symbol;
    logic       w_sample_fire;
    logic       w_byte_done;
    logic       w_sym_adv;
    logic       w_in_ready;
    logic       w_byte_fire;
    logic [7:0] w_shift_next;

    function automatic logic signed [WIDTH-1:0] level(input logic neg);
        return WIDTH'(sign_map(neg, AMP));
    endfunction

    psk_symbol_mapper_symbol_timer #(
        .SPS (SPS)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .load        (w_byte_fire),
        .fire        (w_sample_fire),
        .bpsk        (r_mode),
        .last_sample (w_last_sample),
        .last_symbol (w_last_symbol)
    );

    assign w_sample_fire = r_valid & bus.out_tready;
    assign w_byte_done   = w_sample_fire & w_last_sample & w_last_symbol;
    assign w_sym_adv     = w_sample_fire & w_last_sample & ~w_last_symbol;
    // Ready is taken combinationally from the final sample firing so a waiting
    // byte loads with no bubble; forced low while reset is held.
    assign w_in_ready    = ~rst & (~r_valid | w_byte_done);
    assign w_byte_fire   = bus.in_tvalid & w_in_ready;
    assign w_shift_next  = (r_mode == MODE_BPSK) ? {r_shift[6:0], 1'b0}
                                                 : {r_shift[5:0], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i         <= '0;
            r_q         <= '0;
            r_valid     <= 1'b0;
            r_sym_start <= 1'b0;
            r_mode      <= 1'b0;
            r_shift     <= '0;
        end else if (w_byte_fire) begin
            r_mode      <= bus.is_bpsk;
            r_valid     <= 1'b1;
            r_sym_start <= 1'b1;
            r_i         <= level(bus.in_tdata[7]);
            if (bus.is_bpsk == MODE_BPSK) begin
                r_q     <= '0;
                r_shift <= {bus.in_tdata[6:0], 1'b0};
            end else begin
                r_q     <= level(bus.in_tdata[6]);
                r_shift <= {bus.in_tdata[5:0], 2'b00};
            end
        end else if (w_byte_done) begin
            // Underflow: nothing queued behind the finished byte.
            r_valid     <= 1'b0;
            r_sym_start <= 1'b0;
            r_i         <= '0;
            r_q         <= '0;
            r_shift     <= '0;
        end else if (w_sym_adv) begin
            r_sym_start <= 1'b1;
            r_i         <= level(r_shift[7]);
            r_q         <= (r_mode == MODE_BPSK) ? '0 : level(r_shift[6]);
            r_shift     <= w_shift_next;
        end else if (w_sample_fire) begin
            r_sym_start <= 1'b0;
        end
    end

    assign bus.in_tready    = w_in_ready;
    assign bus.out_I_tdata  = r_i;
    assign bus.out_Q_tdata  = r_q;
    assign bus.out_I_tvalid = r_valid;
    assign bus.out_Q_tvalid = r_valid;
    assign bus.sym_start    = r_sym_start;
    assign bus.busy         = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_psk_symbol_mapper.sv
//------------------------------------------------------------------------------
// Module  : tb_psk_symbol_mapper
// Purpose : Directed self-checking bench for psk_symbol_mapper (SPS=4 DUT plus
//           an SPS=1 DUT).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_psk_symbol_mapper;

    localparam int WIDTH = 16;
    localparam int AMP   = 8192;
    localparam int SPS   = 4;
    localparam logic signed [WIDTH-1:0] c_p = 16'sd8192;
    localparam logic signed [WIDTH-1:0] c_n = -16'sd8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    psk_symbol_mapper_if #(.WIDTH(WIDTH)) bus  ();
    psk_symbol_mapper_if #(.WIDTH(WIDTH)) bus1 ();

    psk_symbol_mapper #(.WIDTH(WIDTH), .AMP(AMP), .SPS(SPS)) u_dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    psk_symbol_mapper #(.WIDTH(WIDTH), .AMP(AMP), .SPS(1)) u_dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] byte_q[$];
    logic       mode_q[$];

    logic signed [WIDTH-1:0] cap_i [256];
    logic signed [WIDTH-1:0] cap_q [256];
    logic                    cap_ss[256];
    logic                    cap_rdy[256];
    int                      cap_cyc[256];
    int                      cap_n;
    int                      stall_viol;

    // Hand-derived symbol signs (+1 -> +AMP, -1 -> -AMP).
    int bpsk_a5[8] = '{-1, 1, -1, 1, 1, -1, 1, -1};
    int qpsk_1b_i[4] = '{1, 1, -1, -1};
    int qpsk_1b_q[4] = '{1, -1, 1, -1};

    function automatic logic signed [WIDTH-1:0] lvl(input int s);
        return (s > 0) ? c_p : c_n;
    endfunction

    // Feeds queued bytes and records every fired sample on the SPS=4 DUT.
    task automatic capture(input int n, input bit stall, input int max_cycles,
                           output bit timeout);
        int cyc;
        bit prev_st;
        bit bf;
        logic signed [WIDTH-1:0] hi, hq;
        logic hs;
        cap_n = 0; cyc = 0; prev_st = 0; stall_viol = 0;
        hi = '0; hq = '0; hs = 1'b0;
        while (cap_n < n && cyc < max_cycles) begin
            @(negedge clk);
            bus.out_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (byte_q.size() > 0) begin
                bus.in_tvalid = 1'b1;
                bus.in_tdata  = byte_q[0];
                bus.is_bpsk   = mode_q[0];
            end else begin
                bus.in_tvalid = 1'b0;
            end
            #1;
            if (prev_st && (bus.out_I_tdata !== hi || bus.out_Q_tdata !== hq ||
                            bus.sym_start !== hs || bus.out_I_tvalid !== 1'b1))
                stall_viol++;
            if (bus.out_I_tvalid && bus.out_tready) begin
                cap_i[cap_n]   = bus.out_I_tdata;
                cap_q[cap_n]   = bus.out_Q_tdata;
                cap_ss[cap_n]  = bus.sym_start;
                cap_rdy[cap_n] = bus.in_tready;
                cap_cyc[cap_n] = cyc;
                cap_n++;
            end
            prev_st = bus.out_I_tvalid && !bus.out_tready;
            hi = bus.out_I_tdata; hq = bus.out_Q_tdata; hs = bus.sym_start;
            bf = bus.in_tvalid && bus.in_tready;
            @(posedge clk);
            if (bf) begin
                void'(byte_q.pop_front());
                void'(mode_q.pop_front());
            end
            cyc++;
        end
        #1;
        bus.in_tvalid  = 1'b0;
        bus.out_tready = 1'b0;
        timeout = (cap_n < n);
    endtask

    task automatic test_reset();
        bus.is_bpsk = 1'b1; bus.in_tdata = '0; bus.in_tvalid = 1'b0; bus.out_tready = 1'b0;
        bus1.is_bpsk = 1'b1; bus1.in_tdata = '0; bus1.in_tvalid = 1'b0; bus1.out_tready = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus.out_I_tvalid !== 1'b0 || bus.out_I_tdata !== '0 || bus.out_Q_tdata !== '0 ||
            bus.sym_start !== 1'b0 || bus.busy !== 1'b0 || bus.out_Q_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b I=%0d Q=%0d ss=%b busy=%b want all 0",
                     bus.out_I_tvalid, bus.out_I_tdata, bus.out_Q_tdata, bus.sym_start, bus.busy);
        end
        checks++;
        if (bus.in_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_tready got %b want 0", bus.in_tready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_tready !== 1'b1 || bus1.in_tready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_tready got %b/%b want 1/1", bus.in_tready, bus1.in_tready);
        end
    endtask

    task automatic test_bpsk();
        bit to;
        byte_q.push_back(8'hA5); mode_q.push_back(1'b1);
        capture(32, 1'b0, 200, to);
        checks++;
        if (to) begin errors++; $display("FAIL bpsk_timeout got %0d samples want 32", cap_n); end
        checks++;
        if (cap_cyc[0] !== 1) begin
            errors++; $display("FAIL bpsk_latency got %0d want 1", cap_cyc[0]);
        end
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (cap_i[k] !== lvl(bpsk_a5[k/4]) || cap_q[k] !== '0 || cap_ss[k] !== (k % 4 == 0)) begin
                errors++;
                $display("FAIL bpsk_sample[%0d] got I=%0d Q=%0d ss=%b want I=%0d Q=0 ss=%b",
                         k, cap_i[k], cap_q[k], cap_ss[k], lvl(bpsk_a5[k/4]), (k % 4 == 0));
            end
        end
        @(negedge clk); #1;
        checks++;
        if (bus.out_I_tvalid !== 1'b0 || bus.out_I_tdata !== '0 || bus.sym_start !== 1'b0 ||
            bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL underflow got valid=%b I=%0d ss=%b busy=%b want 0 0 0 0",
                     bus.out_I_tvalid, bus.out_I_tdata, bus.sym_start, bus.busy);
        end
    endtask

    task automatic test_qpsk();
        bit to;
        byte_q.push_back(8'h1B); mode_q.push_back(1'b0);
        capture(16, 1'b0, 200, to);
        checks++;
        if (to) begin errors++; $display("FAIL qpsk_timeout got %0d samples want 16", cap_n); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (cap_i[k] !== lvl(qpsk_1b_i[k/4]) || cap_q[k] !== lvl(qpsk_1b_q[k/4]) ||
                cap_ss[k] !== (k % 4 == 0)) begin
                errors++;
                $display("FAIL qpsk_sample[%0d] got I=%0d Q=%0d ss=%b want I=%0d Q=%0d ss=%b",
                         k, cap_i[k], cap_q[k], cap_ss[k], lvl(qpsk_1b_i[k/4]),
                         lvl(qpsk_1b_q[k/4]), (k % 4 == 0));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        byte_q.push_back(8'h00); mode_q.push_back(1'b1);
        byte_q.push_back(8'hFF); mode_q.push_back(1'b1);
        capture(64, 1'b0, 300, to);
        checks++;
        if (to) begin errors++; $display("FAIL b2b_timeout got %0d samples want 64", cap_n); end
        checks++;
        if (cap_rdy[31] !== 1'b1 || cap_rdy[30] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_in_tready got s30=%b s31=%b want 0 1", cap_rdy[30], cap_rdy[31]);
        end
        checks++;
        if (cap_cyc[63] - cap_cyc[0] !== 63) begin
            errors++;
            $display("FAIL b2b_contiguous got span %0d want 63", cap_cyc[63] - cap_cyc[0]);
        end
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (cap_i[k] !== ((k < 32) ? c_p : c_n) || cap_q[k] !== '0) begin
                errors++;
                $display("FAIL b2b_sample[%0d] got I=%0d Q=%0d want I=%0d Q=0",
                         k, cap_i[k], cap_q[k], (k < 32) ? c_p : c_n);
            end
        end
    endtask

    task automatic test_stall();
        bit to;
        byte_q.push_back(8'hA5); mode_q.push_back(1'b1);
        capture(32, 1'b1, 2000, to);
        checks++;
        if (to) begin errors++; $display("FAIL stall_timeout got %0d samples want 32", cap_n); end
        checks++;
        if (stall_viol !== 0) begin
            errors++; $display("FAIL stall_stable got %0d changes while stalled want 0", stall_viol);
        end
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (cap_i[k] !== lvl(bpsk_a5[k/4]) || cap_q[k] !== '0 || cap_ss[k] !== (k % 4 == 0)) begin
                errors++;
                $display("FAIL stall_sample[%0d] got I=%0d Q=%0d ss=%b want I=%0d Q=0 ss=%b",
                         k, cap_i[k], cap_q[k], cap_ss[k], lvl(bpsk_a5[k/4]), (k % 4 == 0));
            end
        end
    endtask

    task automatic test_mode_change();
        bit to;
        // The queued QPSK byte drives is_bpsk=0 while the BPSK byte is in flight.
        byte_q.push_back(8'hA5); mode_q.push_back(1'b1);
        byte_q.push_back(8'h1B); mode_q.push_back(1'b0);
        capture(48, 1'b0, 300, to);
        checks++;
        if (to) begin errors++; $display("FAIL mode_timeout got %0d samples want 48", cap_n); end
        for (int k = 0; k < 48; k++) begin
            logic signed [WIDTH-1:0] ei, eq;
            if (k < 32) begin
                ei = lvl(bpsk_a5[k/4]); eq = '0;
            end else begin
                ei = lvl(qpsk_1b_i[(k-32)/4]); eq = lvl(qpsk_1b_q[(k-32)/4]);
            end
            checks++;
            if (cap_i[k] !== ei || cap_q[k] !== eq || cap_ss[k] !== (k % 4 == 0)) begin
                errors++;
                $display("FAIL mode_sample[%0d] got I=%0d Q=%0d ss=%b want I=%0d Q=%0d ss=%b",
                         k, cap_i[k], cap_q[k], cap_ss[k], ei, eq, (k % 4 == 0));
            end
        end
    endtask

    task automatic test_reset_mid_byte();
        bit to;
        byte_q.push_back(8'hA5); mode_q.push_back(1'b1);
        capture(10, 1'b0, 100, to);
        checks++;
        if (to || bus.out_I_tvalid !== 1'b1) begin
            errors++; $display("FAIL midrst_setup got valid=%b samples=%0d want 1 10",
                               bus.out_I_tvalid, cap_n);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_I_tvalid !== 1'b0 || bus.out_I_tdata !== '0 || bus.out_Q_tdata !== '0 ||
            bus.sym_start !== 1'b0 || bus.busy !== 1'b0 || bus.in_tready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got valid=%b I=%0d ss=%b busy=%b rdy=%b want all 0",
                     bus.out_I_tvalid, bus.out_I_tdata, bus.sym_start, bus.busy, bus.in_tready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_tready !== 1'b1 || bus.out_I_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release got rdy=%b valid=%b want 1 0", bus.in_tready, bus.out_I_tvalid);
        end
        byte_q.push_back(8'h80); mode_q.push_back(1'b1);
        capture(32, 1'b0, 200, to);
        checks++;
        if (to || cap_cyc[0] !== 1) begin
            errors++; $display("FAIL midrst_fresh got samples=%0d first_cyc=%0d want 32 1",
                               cap_n, cap_cyc[0]);
        end
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (cap_i[k] !== ((k < 4) ? c_n : c_p) || cap_q[k] !== '0 || cap_ss[k] !== (k % 4 == 0)) begin
                errors++;
                $display("FAIL midrst_sample[%0d] got I=%0d Q=%0d ss=%b want I=%0d Q=0 ss=%b",
                         k, cap_i[k], cap_q[k], cap_ss[k], (k < 4) ? c_n : c_p, (k % 4 == 0));
            end
        end
    endtask

    task automatic test_sps1();
        // BPSK 8'hA5 then QPSK 8'h1B on the SPS=1 DUT, downstream always ready.
        @(negedge clk);
        bus1.out_tready = 1'b1;
        bus1.in_tdata = 8'hA5; bus1.is_bpsk = 1'b1; bus1.in_tvalid = 1'b1;
        #1;
        checks++;
        if (bus1.in_tready !== 1'b1) begin
            errors++; $display("FAIL sps1_ready got %b want 1", bus1.in_tready);
        end
        @(posedge clk); #1;
        bus1.in_tvalid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            checks++;
            if (bus1.out_I_tvalid !== 1'b1 || bus1.sym_start !== 1'b1 ||
                bus1.out_I_tdata !== lvl(bpsk_a5[k]) || bus1.out_Q_tdata !== '0) begin
                errors++;
                $display("FAIL sps1_bpsk[%0d] got v=%b ss=%b I=%0d Q=%0d want 1 1 %0d 0", k,
                         bus1.out_I_tvalid, bus1.sym_start, bus1.out_I_tdata, bus1.out_Q_tdata,
                         lvl(bpsk_a5[k]));
            end
        end
        @(negedge clk); #1;
        checks++;
        if (bus1.out_I_tvalid !== 1'b0 || bus1.sym_start !== 1'b0) begin
            errors++; $display("FAIL sps1_underflow got v=%b ss=%b want 0 0",
                               bus1.out_I_tvalid, bus1.sym_start);
        end
        bus1.in_tdata = 8'h1B; bus1.is_bpsk = 1'b0; bus1.in_tvalid = 1'b1;
        @(posedge clk); #1;
        bus1.in_tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            checks++;
            if (bus1.out_I_tvalid !== 1'b1 || bus1.sym_start !== 1'b1 ||
                bus1.out_I_tdata !== lvl(qpsk_1b_i[k]) || bus1.out_Q_tdata !== lvl(qpsk_1b_q[k])) begin
                errors++;
                $display("FAIL sps1_qpsk[%0d] got v=%b ss=%b I=%0d Q=%0d want 1 1 %0d %0d", k,
                         bus1.out_I_tvalid, bus1.sym_start, bus1.out_I_tdata, bus1.out_Q_tdata,
                         lvl(qpsk_1b_i[k]), lvl(qpsk_1b_q[k]));
            end
        end
        bus1.out_tready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bpsk();
        test_qpsk();
        test_back_to_back();
        test_stall();
        test_mode_change();
        test_reset_mid_byte();
        test_sps1();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
